// File: rtl/dbg_bus_pkg.sv
// Shared types and default widths for the core/debug memory-port arbiter.

package dbg_bus_pkg;

   localparam int unsigned DW_DEF    = 32;
   localparam int unsigned AW_DEF    = 32;
   localparam int unsigned DEPTH_DEF = 4;

   typedef enum logic {SRC_CORE = 1'b0, SRC_DBG = 1'b1} src_e;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_HOLD = 1'b1} arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_demux_tag_fifo.sv
// In-order FIFO of request source ids; head selects where each response goes.

module tag_fifo
   import dbg_bus_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  src_e                     push_src_i,
   input  logic                     pop_i,
   output src_e                     head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   src_e            mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_src_i;
   end

endmodule

// File: rtl/mux2_32.sv
// Datapath 2:1 mux used to steer each request field; width defaults to 32.

module mux2_32 #(
   parameter int unsigned W = 32
) (
   input  logic         sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter_demux.sv
// Shares one memory port between the core (src 0) and debug module (src 1),
// routing each in-order response back to the source that issued it.

module mem_port_arbiter_demux
   import dbg_bus_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    core_req_valid,
   output logic                    core_req_ready,
   input  logic [AW-1:0]           core_addr,
   input  logic                    core_we,
   input  logic [DW-1:0]           core_wdata,
   input  logic                    dbg_req_valid,
   output logic                    dbg_req_ready,
   input  logic [AW-1:0]           dbg_addr,
   input  logic                    dbg_we,
   input  logic [DW-1:0]           dbg_wdata,
   output logic                    core_rsp_valid,
   output logic [DW-1:0]           core_rdata,
   output logic                    dbg_rsp_valid,
   output logic [DW-1:0]           dbg_rdata,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [AW-1:0]           mem_addr,
   output logic                    mem_we,
   output logic [DW-1:0]           mem_wdata,
   input  logic                    mem_rsp_valid,
   input  logic [DW-1:0]           mem_rdata,
   output logic                    sel,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    err
);

   arb_state_e state_q;
   src_e       sel_q;
   src_e       gnt;
   logic       gnt_valid;
   logic       accept;
   logic       rsp_pop;
   logic       err_q, err_d;
   src_e       fifo_head;
   logic       fifo_full;
   logic       fifo_empty;

   // Debug wins in IDLE; a stalled handshake freezes the registered grant.
   always_comb begin
      gnt = SRC_CORE;
      if (state_q == ARB_HOLD) gnt = sel_q;
      else if (dbg_req_valid)  gnt = SRC_DBG;
   end

   assign sel            = (gnt == SRC_DBG);
   assign gnt_valid      = sel ? dbg_req_valid : core_req_valid;
   assign mem_req_valid  = gnt_valid & ~fifo_full;
   assign accept         = mem_req_valid & mem_req_ready;
   assign core_req_ready = accept & ~sel;
   assign dbg_req_ready  = accept & sel;

   mux2_32 #(.W(AW)) u_mux_addr (
      .sel_i (sel),
      .a_i   (core_addr),
      .b_i   (dbg_addr),
      .y_o   (mem_addr)
   );

   mux2_32 #(.W(DW)) u_mux_wdata (
      .sel_i (sel),
      .a_i   (core_wdata),
      .b_i   (dbg_wdata),
      .y_o   (mem_wdata)
   );

   mux2_32 #(.W(1)) u_mux_we (
      .sel_i (sel),
      .a_i   (core_we),
      .b_i   (dbg_we),
      .y_o   (mem_we)
   );

   tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (accept),
      .push_src_i (gnt),
      .pop_i      (rsp_pop),
      .head_o     (fifo_head),
      .count_o    (outstanding),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // A response with nothing in flight is dropped and flagged.
   assign rsp_pop        = mem_rsp_valid & ~fifo_empty;
   assign core_rsp_valid = rsp_pop & (fifo_head == SRC_CORE);
   assign dbg_rsp_valid  = rsp_pop & (fifo_head == SRC_DBG);
   assign core_rdata     = mem_rdata;
   assign dbg_rdata      = mem_rdata;
   assign err_d          = err_q | (mem_rsp_valid & fifo_empty);
   assign err            = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         sel_q   <= SRC_CORE;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         case (state_q)
            ARB_IDLE: begin
               if (mem_req_valid && !mem_req_ready) begin
                  state_q <= ARB_HOLD;
                  sel_q   <= gnt;
               end
            end
            ARB_HOLD: begin
               if (accept || !gnt_valid) state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule
